// File: rtl/vga_timing_monitor_if.sv
// Timing-stream bundle between a VGA timing source and the timing monitor.
// The master drives the blank/sync stream and observes the recovered timing.
interface vga_timing_monitor_if;
  logic        hblnk_in;
  logic        vblnk_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [10:0] h_total;
  logic [10:0] v_total;
  logic [7:0]  hsync_width;
  logic        locked;
  logic        timing_err;

  modport master (
    output hblnk_in, vblnk_in, hsync_in, vsync_in,
    input  hcount, vcount, h_total, v_total, hsync_width, locked, timing_err
  );

  modport slave (
    input  hblnk_in, vblnk_in, hsync_in, vsync_in,
    output hcount, vcount, h_total, v_total, hsync_width, locked, timing_err
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Recovers pixel/line position from blanking edges, measures line/frame/hsync lengths,
// and declares lock after LOCK_FRAMES consecutive frames of uniform, unchanged geometry.
module vga_timing_monitor #(
  parameter int LOCK_FRAMES = 2
) (
  input logic                 pclk,
  input logic                 rst,
  vga_timing_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] CNT_MAX  = 11'd2047;
  localparam logic [7:0]  HS_MAX   = 8'd255;
  localparam logic [7:0]  LOCK_TGT = 8'(LOCK_FRAMES);

  logic        hblnk_r, vblnk_r, hsync_r, vsync_r;
  logic        hblnk_d_r, vblnk_d_r, hsync_d_r, vsync_d_r;
  logic [10:0] hcount_r, vcount_r, h_total_r, v_total_r, first_len_r;
  logic [7:0]  hsync_width_r, hs_cnt_r, frame_cnt_r;
  logic        seen_ls_r, seen_fs_r, v_loaded_r, vpend_r;
  logic        have_first_r, lines_ok_r;
  logic        locked_r, timing_err_r;
  state_t      state_r;

  logic        ls_s, vfall_s, fs_s, hsfall_s, vs_err_s, hsat_s, vsat_s;
  logic [10:0] hmeas_s, vmeas_s;
  logic        line_ok_s, frame_ok_s, lock_err_s;
  logic [7:0]  frame_cnt_inc_s;

  // Edge detection, saturating measurements and consistency decisions
  always_comb begin
    ls_s       = hblnk_d_r & ~hblnk_r;
    vfall_s    = vblnk_d_r & ~vblnk_r;
    fs_s       = ls_s & (vpend_r | vfall_s);
    hsfall_s   = hsync_d_r & ~hsync_r;
    vs_err_s   = (vsync_r ^ vsync_d_r) & ~vblnk_r;
    hsat_s     = (hcount_r == CNT_MAX);
    vsat_s     = (vcount_r == CNT_MAX);
    hmeas_s    = hsat_s ? CNT_MAX : (hcount_r + 11'd1);
    vmeas_s    = vsat_s ? CNT_MAX : (vcount_r + 11'd1);
    line_ok_s  = ~have_first_r | (hmeas_s == first_len_r);
    // With no earlier frame total to compare against, the frame length is taken as the reference
    frame_ok_s = lines_ok_r & line_ok_s & (~v_loaded_r | (vmeas_s == v_total_r));
    frame_cnt_inc_s = (frame_cnt_r == 8'hFF) ? 8'hFF : (frame_cnt_r + 8'd1);
    lock_err_s = 1'b0;
    if (state_r == LOCKED) begin
      lock_err_s = vs_err_s | hsat_s | vsat_s
                 | (ls_s & (hmeas_s != h_total_r))
                 | (fs_s & (vmeas_s != v_total_r));
    end else begin
      lock_err_s = 1'b0;
    end
  end

  // Input sample stage plus one cycle of history for edge detection
  always_ff @(posedge pclk) begin
    if (rst) begin
      hblnk_r   <= 1'b0;
      vblnk_r   <= 1'b0;
      hsync_r   <= 1'b0;
      vsync_r   <= 1'b0;
      hblnk_d_r <= 1'b0;
      vblnk_d_r <= 1'b0;
      hsync_d_r <= 1'b0;
      vsync_d_r <= 1'b0;
    end else begin
      hblnk_r   <= mon.hblnk_in;
      vblnk_r   <= mon.vblnk_in;
      hsync_r   <= mon.hsync_in;
      vsync_r   <= mon.vsync_in;
      hblnk_d_r <= hblnk_r;
      vblnk_d_r <= vblnk_r;
      hsync_d_r <= hsync_r;
      vsync_d_r <= vsync_r;
    end
  end

  // Position counters and line/frame totals
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_r   <= 11'd0;
      vcount_r   <= 11'd0;
      h_total_r  <= 11'd0;
      v_total_r  <= 11'd0;
      seen_ls_r  <= 1'b0;
      seen_fs_r  <= 1'b0;
      v_loaded_r <= 1'b0;
      vpend_r    <= 1'b0;
    end else begin
      if (ls_s) begin
        hcount_r  <= 11'd0;
        seen_ls_r <= 1'b1;
        if (seen_ls_r) begin
          h_total_r <= hmeas_s;
        end
      end else if (!hsat_s) begin
        hcount_r <= hcount_r + 11'd1;
      end
      if (fs_s) begin
        vcount_r  <= 11'd0;
        vpend_r   <= 1'b0;
        seen_fs_r <= 1'b1;
        if (seen_fs_r) begin
          v_total_r  <= vmeas_s;
          v_loaded_r <= 1'b1;
        end
      end else begin
        if (ls_s && !vsat_s) begin
          vcount_r <= vcount_r + 11'd1;
        end
        if (vfall_s) begin
          vpend_r <= 1'b1;
        end
      end
    end
  end

  // Hsync high-time measurement, published on the sync falling edge
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_cnt_r      <= 8'd0;
      hsync_width_r <= 8'd0;
    end else if (hsfall_s) begin
      hsync_width_r <= hs_cnt_r;
      hs_cnt_r      <= 8'd0;
    end else if (hsync_r && (hs_cnt_r != HS_MAX)) begin
      hs_cnt_r <= hs_cnt_r + 8'd1;
    end
  end

  // Lock FSM with per-frame line-uniformity tracking
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r      <= SEARCH;
      frame_cnt_r  <= 8'd0;
      first_len_r  <= 11'd0;
      have_first_r <= 1'b0;
      lines_ok_r   <= 1'b0;
      locked_r     <= 1'b0;
      timing_err_r <= 1'b0;
    end else begin
      timing_err_r <= 1'b0;
      if (fs_s) begin
        have_first_r <= 1'b0;
        lines_ok_r   <= 1'b1;
      end else if (ls_s) begin
        if (!have_first_r) begin
          first_len_r  <= hmeas_s;
          have_first_r <= 1'b1;
        end else if (hmeas_s != first_len_r) begin
          lines_ok_r <= 1'b0;
        end
      end
      case (state_r)
        SEARCH: begin
          locked_r <= 1'b0;
          if (fs_s) begin
            state_r     <= MEASURE;
            frame_cnt_r <= 8'd0;
          end
        end
        MEASURE: begin
          locked_r <= 1'b0;
          if (vs_err_s) begin
            // The frame carrying the stray vsync can never count as consistent
            frame_cnt_r <= 8'd0;
            lines_ok_r  <= 1'b0;
          end else if (fs_s) begin
            if (!frame_ok_s) begin
              frame_cnt_r <= 8'd0;
            end else if (frame_cnt_inc_s >= LOCK_TGT) begin
              state_r     <= LOCKED;
              locked_r    <= 1'b1;
              frame_cnt_r <= 8'd0;
            end else begin
              frame_cnt_r <= frame_cnt_inc_s;
            end
          end
        end
        LOCKED: begin
          if (lock_err_s) begin
            state_r      <= SEARCH;
            locked_r     <= 1'b0;
            timing_err_r <= 1'b1;
            frame_cnt_r  <= 8'd0;
          end
        end
        default: begin
          state_r     <= SEARCH;
          locked_r    <= 1'b0;
          frame_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign mon.hcount      = hcount_r;
  assign mon.vcount      = vcount_r;
  assign mon.h_total     = h_total_r;
  assign mon.v_total     = v_total_r;
  assign mon.hsync_width = hsync_width_r;
  assign mon.locked      = locked_r;
  assign mon.timing_err  = timing_err_r;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor: synthetic blank/sync streams with hand-computed
// expectations for counters, totals, lock acquisition and loss-of-lock pulses.
module tb_vga_timing_monitor;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int tests_run    = 0;
  int tests_failed = 0;
  int err_pulses   = 0;
  int hlen, hact, hs0, hsw, vlen, vact, vs0, vsw, glitch_line;

  vga_timing_monitor_if vif();
  vga_timing_monitor_if vif4();

  vga_timing_monitor #(.LOCK_FRAMES(2)) dut  (.pclk(pclk), .rst(rst), .mon(vif.slave));
  vga_timing_monitor #(.LOCK_FRAMES(4)) dut4 (.pclk(pclk), .rst(rst), .mon(vif4.slave));

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (vif.timing_err === 1'b1) err_pulses++;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_pix(input logic hb, input logic vb, input logic hs, input logic vs);
    vif.hblnk_in  = hb;  vif.vblnk_in  = vb;  vif.hsync_in  = hs;  vif.vsync_in  = vs;
    vif4.hblnk_in = hb;  vif4.vblnk_in = vb;  vif4.hsync_in = hs;  vif4.vsync_in = vs;
    tick();
  endtask

  task automatic drive_line(input int h0, input int len, input int v);
    for (int h = h0; h < len; h++) begin
      drive_pix(h >= hact, v >= vact, (h >= hs0) && (h < hs0 + hsw),
                ((v >= vs0) && (v < vs0 + vsw)) || ((v == glitch_line) && (h >= 2) && (h < 4)));
    end
  endtask

  task automatic drive_frame(input int bad_line, input int bad_len);
    for (int v = 0; v < vlen; v++) begin
      drive_line(0, (v == bad_line) ? bad_len : hlen, v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_pix(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_small();
    hlen = 24; hact = 16; hs0 = 18; hsw = 3;
    vlen = 10; vact = 6;  vs0 = 7;  vsw = 2;
    glitch_line = -1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_pix(1'b1, 1'b1, 1'b1, 1'b1);
    drive_pix(1'b0, 1'b0, 1'b1, 1'b1);
    drive_pix(1'b1, 1'b1, 1'b1, 1'b1);
    tests_run++; if (vif.hcount !== 11'd0) begin tests_failed++; $display("FAIL reset_hcount: got %0d expected 0", vif.hcount); end
    tests_run++; if (vif.vcount !== 11'd0) begin tests_failed++; $display("FAIL reset_vcount: got %0d expected 0", vif.vcount); end
    tests_run++; if (vif.h_total !== 11'd0) begin tests_failed++; $display("FAIL reset_h_total: got %0d expected 0", vif.h_total); end
    tests_run++; if (vif.v_total !== 11'd0) begin tests_failed++; $display("FAIL reset_v_total: got %0d expected 0", vif.v_total); end
    tests_run++; if (vif.hsync_width !== 8'd0) begin tests_failed++; $display("FAIL reset_hsync_width: got %0d expected 0", vif.hsync_width); end
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %0b expected 0", vif.locked); end
    tests_run++; if (vif.timing_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timing_err: got %0b expected 0", vif.timing_err); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    set_small();
    idle(5);
    drive_frame(-1, 0);
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early: got %0b expected 0", vif.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL lock_locked: got %0b expected 1", vif.locked); end
    tests_run++; if (vif.h_total !== 11'd24) begin tests_failed++; $display("FAIL lock_h_total: got %0d expected 24", vif.h_total); end
    tests_run++; if (vif.v_total !== 11'd10) begin tests_failed++; $display("FAIL lock_v_total: got %0d expected 10", vif.v_total); end
    tests_run++; if (vif.hsync_width !== 8'd3) begin tests_failed++; $display("FAIL lock_hsync_width: got %0d expected 3", vif.hsync_width); end
    tests_run++; if (vif.hcount !== 11'd22) begin tests_failed++; $display("FAIL lock_hcount: got %0d expected 22", vif.hcount); end
    tests_run++; if (vif.vcount !== 11'd9) begin tests_failed++; $display("FAIL lock_vcount: got %0d expected 9", vif.vcount); end
    tests_run++; if (err_pulses !== 0) begin tests_failed++; $display("FAIL lock_no_err: got %0d expected 0", err_pulses); end
  endtask

  task automatic test_long_line();
    int e0;
    e0 = err_pulses;
    drive_frame(3, 25);
    tests_run++; if (err_pulses - e0 !== 1) begin tests_failed++; $display("FAIL long_err_pulse: got %0d expected 1", err_pulses - e0); end
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL long_unlocked: got %0b expected 0", vif.locked); end
    tests_run++; if (dut.state_r !== 2'd0) begin tests_failed++; $display("FAIL long_state: got %0d expected 0", dut.state_r); end
    tests_run++; if (vif.h_total !== 11'd24) begin tests_failed++; $display("FAIL long_h_total: got %0d expected 24", vif.h_total); end
    drive_frame(-1, 0);
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL long_relock_early: got %0b expected 0", vif.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL long_relock: got %0b expected 1", vif.locked); end
    tests_run++; if (err_pulses - e0 !== 1) begin tests_failed++; $display("FAIL long_err_total: got %0d expected 1", err_pulses - e0); end
  endtask

  task automatic test_hold_blank();
    int e0;
    e0 = err_pulses;
    drive_line(0, hlen, 0);
    drive_line(0, hlen, 1);
    drive_line(0, hact + 3000, 2);
    tests_run++; if (vif.hcount !== 11'd2047) begin tests_failed++; $display("FAIL hold_hcount_sat: got %0d expected 2047", vif.hcount); end
    tests_run++; if (err_pulses - e0 !== 1) begin tests_failed++; $display("FAIL hold_err_pulse: got %0d expected 1", err_pulses - e0); end
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL hold_unlocked: got %0b expected 0", vif.locked); end
    tests_run++; if (vif.timing_err !== 1'b0) begin tests_failed++; $display("FAIL hold_err_low: got %0b expected 0", vif.timing_err); end
    drive_line(0, hlen, 3);
    tests_run++; if (vif.h_total !== 11'd2047) begin tests_failed++; $display("FAIL hold_h_total_sat: got %0d expected 2047", vif.h_total); end
    for (int v = 4; v < vlen; v++) drive_line(0, hlen, v);
    drive_frame(-1, 0);
    drive_frame(-1, 0);
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL hold_relock: got %0b expected 1", vif.locked); end
  endtask

  task automatic test_reset_midline();
    for (int v = 0; v < 5; v++) drive_line(0, hlen, v);
    drive_line(0, 10, 5);
    rst = 1'b1;
    tick();
    tests_run++; if (vif.hcount !== 11'd0) begin tests_failed++; $display("FAIL rstmid_hcount: got %0d expected 0", vif.hcount); end
    tests_run++; if (vif.vcount !== 11'd0) begin tests_failed++; $display("FAIL rstmid_vcount: got %0d expected 0", vif.vcount); end
    tests_run++; if (vif.h_total !== 11'd0) begin tests_failed++; $display("FAIL rstmid_h_total: got %0d expected 0", vif.h_total); end
    tests_run++; if (vif.v_total !== 11'd0) begin tests_failed++; $display("FAIL rstmid_v_total: got %0d expected 0", vif.v_total); end
    tests_run++; if (vif.hsync_width !== 8'd0) begin tests_failed++; $display("FAIL rstmid_hsync_width: got %0d expected 0", vif.hsync_width); end
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL rstmid_locked: got %0b expected 0", vif.locked); end
    rst = 1'b0;
    drive_line(10, hlen, 5);
    drive_line(0, hlen, 6);
    tests_run++; if (vif.h_total !== 11'd0) begin tests_failed++; $display("FAIL rstmid_first_ls: got %0d expected 0", vif.h_total); end
    for (int v = 7; v < vlen; v++) drive_line(0, hlen, v);
    drive_frame(-1, 0);
    tests_run++; if (vif.v_total !== 11'd0) begin tests_failed++; $display("FAIL rstmid_first_fs: got %0d expected 0", vif.v_total); end
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL rstmid_lock_x: got %0b expected 0", vif.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL rstmid_lock_y: got %0b expected 0", vif.locked); end
    tests_run++; if (vif.v_total !== 11'd10) begin tests_failed++; $display("FAIL rstmid_v_total_y: got %0d expected 10", vif.v_total); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL rstmid_relock: got %0b expected 1", vif.locked); end
  endtask

  task automatic test_lock_frames4();
    tests_run++; if (vif4.locked !== 1'b0) begin tests_failed++; $display("FAIL lf4_after3: got %0b expected 0", vif4.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif4.locked !== 1'b0) begin tests_failed++; $display("FAIL lf4_after4: got %0b expected 0", vif4.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif4.locked !== 1'b1) begin tests_failed++; $display("FAIL lf4_locked: got %0b expected 1", vif4.locked); end
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL lf4_main_still: got %0b expected 1", vif.locked); end
  endtask

  task automatic test_vsync_glitch();
    int e0;
    pulse_reset();
    idle(5);
    e0 = err_pulses;
    drive_frame(-1, 0);
    glitch_line = 2;
    drive_frame(-1, 0);
    glitch_line = -1;
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL glitch_f2: got %0b expected 0", vif.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL glitch_f3: got %0b expected 0", vif.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL glitch_relock: got %0b expected 1", vif.locked); end
    tests_run++; if (err_pulses - e0 !== 0) begin tests_failed++; $display("FAIL glitch_no_err: got %0d expected 0", err_pulses - e0); end
  endtask

  task automatic test_full_geometry();
    pulse_reset();
    hlen = 1056; hact = 800; hs0 = 840; hsw = 128;
    vlen = 628;  vact = 600; vs0 = 601; vsw = 4;
    glitch_line = -1;
    idle(5);
    for (int i = 0; i < 3; i++) drive_line(0, hlen, 610);
    tests_run++; if (vif.h_total !== 11'd1056) begin tests_failed++; $display("FAIL full_h_total: got %0d expected 1056", vif.h_total); end
    tests_run++; if (vif.hsync_width !== 8'd128) begin tests_failed++; $display("FAIL full_hsync_width: got %0d expected 128", vif.hsync_width); end
    hlen = 8; hact = 4; hs0 = 5; hsw = 2;
    drive_frame(-1, 0);
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b0) begin tests_failed++; $display("FAIL full_lock_early: got %0b expected 0", vif.locked); end
    drive_frame(-1, 0);
    tests_run++; if (vif.locked !== 1'b1) begin tests_failed++; $display("FAIL full_locked: got %0b expected 1", vif.locked); end
    tests_run++; if (vif.v_total !== 11'd628) begin tests_failed++; $display("FAIL full_v_total: got %0d expected 628", vif.v_total); end
    tests_run++; if (vif.vcount !== 11'd627) begin tests_failed++; $display("FAIL full_vcount: got %0d expected 627", vif.vcount); end
  endtask

  initial begin
    set_small();
    vif.hblnk_in = 1'b1;  vif.vblnk_in = 1'b1;  vif.hsync_in = 1'b0;  vif.vsync_in = 1'b0;
    vif4.hblnk_in = 1'b1; vif4.vblnk_in = 1'b1; vif4.hsync_in = 1'b0; vif4.vsync_in = 1'b0;
    test_reset();
    test_lock();
    test_long_line();
    test_hold_blank();
    test_reset_midline();
    test_lock_frames4();
    test_vsync_glitch();
    test_full_geometry();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter LOCK_FRAMES, default 2: number of consecutive consistent frames required before locked asserts.
REQ-002 Port pclk, input, 1: pixel clock; all logic on rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port hblnk_in, input, 1: horizontal blank from the upstream timing source; high = outside active line.
REQ-005 Port vblnk_in, input, 1: vertical blank; high = outside active frame.
REQ-006 Port hsync_in, input, 1: horizontal sync; active-high.
REQ-007 Port vsync_in, input, 1: vertical sync; active-high.
REQ-008 Port hcount, output, 11: recovered horizontal pixel index.
REQ-009 Port vcount, output, 11: recovered line index.
REQ-010 Port h_total, output, 11: last measured line length in pclk.
REQ-011 Port v_total, output, 11: last measured frame length in lines.
REQ-012 Port hsync_width, output, 8: last measured hsync high width in pclk; saturates at 255.
REQ-013 Port locked, output, 1: timing stable.
REQ-014 Port timing_err, output, 1: one-cycle pulse on loss of lock.

Function
REQ-015 All inputs are registered once; a line start (LS) is a sampled hblnk_in 1->0 transition; a frame start (FS) is the first LS after a sampled vblnk_in 1->0 transition.
REQ-016 hcount is 0 in the cycle after LS is detected, then increments by 1 per pclk, saturating at 2047 if no further LS occurs.
REQ-017 On each LS, h_total is loaded with (hcount + 1); the first LS after reset loads nothing.
REQ-018 vcount is 0 from FS, increments by 1 on each subsequent LS, and saturates at 2047.
REQ-019 On each FS, v_total is loaded with (vcount + 1); the first FS after reset loads nothing.
REQ-020 hsync_width counts sampled hsync_in high cycles and is loaded on the hsync_in 1->0 transition.
REQ-021 The FSM states are SEARCH, MEASURE, and LOCKED.
REQ-022 SEARCH -> MEASURE occurs on the first FS.
REQ-023 In MEASURE, a frame is consistent when every line length equals the first line length of that frame and v_total equals the previous frame's v_total.
REQ-024 MEASURE -> LOCKED occurs after LOCK_FRAMES consecutive consistent frames; an inconsistent frame restarts the count in MEASURE.
REQ-025 In LOCKED, any line length differing from h_total, or any frame length differing from v_total, causes LOCKED -> SEARCH with timing_err=1 for exactly one cycle.
REQ-026 A vsync_in edge sampled while vblnk_in=0 is treated as a frame error, with the same response as REQ-025 in LOCKED and a count restart in MEASURE.
REQ-027 locked=1 only in LOCKED.
REQ-028 If LS and FS occur on the same cycle, FS rules apply (vcount=0, v_total load).
REQ-029 Counter saturation (hcount=2047 or vcount=2047) in LOCKED is a mismatch per REQ-025.

Reset
REQ-030 While rst=1, the following all hold 0: hcount, vcount, h_total, v_total, hsync_width, locked, timing_err, and the input sample registers; state=SEARCH.
REQ-031 rst asserted mid-frame takes effect on the next edge; after release, measurement restarts from the SEARCH rules with no stale totals.

Verification
REQ-032 Drive a 1056x628 stream (800/600 active, hsync 128 at 840, vsync 4 at 601) -> locked=1 after the 2nd consistent frame; h_total=1056, v_total=628, hsync_width=128.
REQ-033 While locked, lengthen one line to 1057 -> timing_err pulses 1 cycle, locked=0, state=SEARCH, relock after 2 clean frames.
REQ-034 Hold hblnk_in=1 for 3000 cycles while locked -> hcount holds at 2047, timing_err pulses, locked=0.
REQ-035 Assert rst for 1 cycle mid-line while locked -> all outputs 0 the next cycle; relock needs FS plus 2 frames.
REQ-036 Pulse vsync_in during active video (vblnk_in=0) in MEASURE -> consistent-frame count restarts; locked remains 0.
REQ-037 Set LOCK_FRAMES=4 -> locked rises only after 4 consistent frames.
